// File: rtl/barrel_shift_pkg.sv
//==============================================================================
// Module   : barrel_shift_pkg
// Brief    : Shared mode encoding and pipeline-depth helper for barrel_shift_pipe.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package barrel_shift_pkg;

   typedef enum logic [1:0] {
      MODE_SLL = 2'b00,
      MODE_SRL = 2'b01,
      MODE_SRA = 2'b10,
      MODE_ROL = 2'b11
   } mode_t;

   // Number of register slots: one after every reg_every stages plus the final stage.
   function automatic int calc_nreg(input int shamt_w, input int reg_every);
      return (shamt_w + reg_every - 1) / reg_every;
   endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_shift_stage.sv
//==============================================================================
// Module   : barrel_shift_stage
// Brief    : One combinational conditional shift-by-AMOUNT stage.
//            Macro BARREL_SHIFT_ROTATE_EN enables rotate-left for mode 11.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module barrel_shift_stage
   import barrel_shift_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int AMOUNT = 1
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_en,
   input  logic [1:0]       i_mode,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] w_shifted;

   always_comb begin
      w_shifted = i_data << AMOUNT;
      case (mode_t'(i_mode))
         MODE_SRL: w_shifted = i_data >> AMOUNT;
         MODE_SRA: w_shifted = {{AMOUNT{i_data[WIDTH-1]}}, i_data[WIDTH-1:AMOUNT]};
`ifdef BARREL_SHIFT_ROTATE_EN
         MODE_ROL: w_shifted = {i_data[WIDTH-1-AMOUNT:0], i_data[WIDTH-1:WIDTH-AMOUNT]};
`endif
         default:  w_shifted = i_data << AMOUNT;
      endcase
   end

   assign o_data = i_en ? w_shifted : i_data;

endmodule

`default_nettype wire

// File: rtl/barrel_shift_pipe.sv
//==============================================================================
// Module   : barrel_shift_pipe
// Brief    : Pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready flow.
//            Macro BARREL_SHIFT_ROTATE_EN enables rotate-left; otherwise mode 11 = SLL.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module barrel_shift_pipe
   import barrel_shift_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int REG_EVERY  = 1,
   localparam int SHAMT_W   = $clog2(WIDTH)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [WIDTH-1:0]   i_data,
   input  logic [SHAMT_W-1:0] i_shamt,
   input  logic [1:0]         i_mode,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [WIDTH-1:0]   o_data
);

   localparam int NREG = calc_nreg(SHAMT_W, REG_EVERY);

   logic [NREG-1:0]    r_valid;
   logic [WIDTH-1:0]   r_data      [NREG];
   logic [SHAMT_W-1:0] r_shamt     [NREG];
   logic [1:0]         r_mode      [NREG];

   logic [NREG-1:0]    w_src_valid;
   logic [WIDTH-1:0]   w_src_data  [NREG];
   logic [SHAMT_W-1:0] w_src_shamt [NREG];
   logic [1:0]         w_src_mode  [NREG];
   logic [WIDTH-1:0]   w_next_data [NREG];
   logic [NREG-1:0]    w_load;
   logic               w_out_take;

   // Slot n is fed by slot n-1; slot 0 is fed by the input port.
   assign w_src_valid[0] = i_valid;
   assign w_src_data[0]  = i_data;
   assign w_src_shamt[0] = i_shamt;
   assign w_src_mode[0]  = i_mode;

   for (genvar n = 1; n < NREG; n++) begin : g_src
      assign w_src_valid[n] = r_valid[n-1];
      assign w_src_data[n]  = r_data[n-1];
      assign w_src_shamt[n] = r_shamt[n-1];
      assign w_src_mode[n]  = r_mode[n-1];
   end

   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      localparam int SLOT = k / REG_EVERY;
      logic [WIDTH-1:0] w_in;
      logic [WIDTH-1:0] w_out;

      if (k % REG_EVERY == 0) begin : g_head
         assign w_in = w_src_data[SLOT];
      end else begin : g_body
         assign w_in = g_stage[k-1].w_out;
      end

      barrel_shift_stage #(
         .WIDTH  (WIDTH),
         .AMOUNT (1 << k)
      ) u_stage (
         .i_data (w_in),
         .i_en   (w_src_shamt[SLOT][k]),
         .i_mode (w_src_mode[SLOT]),
         .o_data (w_out)
      );
   end

   for (genvar n = 0; n < NREG; n++) begin : g_tap
      localparam int LAST = (((n + 1) * REG_EVERY < SHAMT_W) ? (n + 1) * REG_EVERY : SHAMT_W) - 1;
      assign w_next_data[n] = g_stage[LAST].w_out;
   end

   // A slot may load when empty or when its downstream neighbour is loading from it.
   always_comb begin
      w_out_take     = r_valid[NREG-1] & i_ready;
      w_load         = '0;
      w_load[NREG-1] = ~r_valid[NREG-1] | w_out_take;
      for (int n = NREG - 2; n >= 0; n--) begin
         w_load[n] = ~r_valid[n] | w_load[n+1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_valid <= '0;
         for (int n = 0; n < NREG; n++) begin
            r_data[n]  <= '0;
            r_shamt[n] <= '0;
            r_mode[n]  <= '0;
         end
      end else begin
         for (int n = 0; n < NREG; n++) begin
            if (w_load[n]) begin
               r_valid[n] <= w_src_valid[n];
               r_data[n]  <= w_next_data[n];
               r_shamt[n] <= w_src_shamt[n];
               r_mode[n]  <= w_src_mode[n];
            end
         end
      end
   end

   // The last slot's control fields have no downstream consumer.
   logic w_unused_tail;
   assign w_unused_tail = ^{r_shamt[NREG-1], r_mode[NREG-1]};

   assign o_ready = i_rst_n & w_load[0];
   assign o_valid = i_rst_n & r_valid[NREG-1];
   assign o_data  = r_data[NREG-1];

endmodule

`default_nettype wire

// File: tb/tb_barrel_shift_pipe.sv
//==============================================================================
// Module   : tb_barrel_shift_pipe
// Brief    : Directed self-checking bench for barrel_shift_pipe (32/1 and 8/2 builds).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_barrel_shift_pipe;

   logic        clk;
   logic        rst_n;

   logic        valid, ready_up, ready;
   logic [31:0] data;
   logic [4:0]  shamt;
   logic [1:0]  mode;
   logic        out_valid;
   logic [31:0] out_data;

   logic        valid8, ready_up8, ready8;
   logic [7:0]  data8;
   logic [2:0]  shamt8;
   logic [1:0]  mode8;
   logic        out_valid8;
   logic [7:0]  out_data8;

   int n_checks;
   int n_fail;

   barrel_shift_pipe #(.WIDTH(32), .REG_EVERY(1)) u_dut32 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (valid),
      .o_ready (ready_up),
      .i_data  (data),
      .i_shamt (shamt),
      .i_mode  (mode),
      .o_valid (out_valid),
      .i_ready (ready),
      .o_data  (out_data)
   );

   barrel_shift_pipe #(.WIDTH(8), .REG_EVERY(2)) u_dut8 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (valid8),
      .o_ready (ready_up8),
      .i_data  (data8),
      .i_shamt (shamt8),
      .i_mode  (mode8),
      .o_valid (out_valid8),
      .i_ready (ready8),
      .o_data  (out_data8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m);
      case (m)
         2'b00:   return d << s;
         2'b01:   return d >> s;
         2'b10:   return 32'($signed(d) >>> s);
`ifdef BARREL_SHIFT_ROTATE_EN
         default: return (s == 5'd0) ? d : ((d << s) | (d >> (32 - int'(s))));
`else
         default: return d << s;
`endif
      endcase
   endfunction

   task automatic run32(input string tag, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] m, input logic [31:0] exp);
      int lat;
      valid = 1'b1; data = d; shamt = s; mode = m; ready = 1'b1;
      step();
      valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'd5);
      check({tag, "_data"}, 64'(out_data), 64'(exp));
      step();
   endtask

   task automatic run8(input string tag, input logic [7:0] d, input logic [2:0] s,
                       input logic [1:0] m, input logic [7:0] exp);
      int lat;
      valid8 = 1'b1; data8 = d; shamt8 = s; mode8 = m; ready8 = 1'b1;
      step();
      valid8 = 1'b0;
      lat = 1;
      while (!out_valid8 && lat < 20) begin
         step();
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'd2);
      check({tag, "_data"}, 64'(out_data8), 64'(exp));
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] exp_q[$];
      logic [31:0] hold_data;
      logic        stalled;
      int          sent, got, cyc, acc_at_drop, seen, w;

      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      valid = 1'b0; data = '0; shamt = '0; mode = '0; ready = 1'b1;
      valid8 = 1'b0; data8 = '0; shamt8 = '0; mode8 = '0; ready8 = 1'b1;

      // Reset state
      step();
      step();
      check("rst_o_valid", 64'(out_valid), 64'd0);
      check("rst_o_ready", 64'(ready_up), 64'd0);
      check("rst_o_data", 64'(out_data), 64'd0);
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", 64'(ready_up), 64'd1);
      check("post_rst_valid", 64'(out_valid), 64'd0);

      // Directed single beats
      run32("sra4", 32'h8000_0001, 5'd4, 2'b10, 32'hF800_0000);
`ifdef BARREL_SHIFT_ROTATE_EN
      run32("mode3_s1", 32'h8000_0001, 5'd1, 2'b11, 32'h0000_0003);
      run32("mode3_s8", 32'hABCD_1234, 5'd8, 2'b11, 32'hCD12_34AB);
`else
      run32("mode3_s1", 32'h8000_0001, 5'd1, 2'b11, 32'h0000_0002);
      run32("mode3_s8", 32'hABCD_1234, 5'd8, 2'b11, 32'hCD12_3400);
`endif
      run32("sll31", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
      run32("srl31", 32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001);
      run32("sra31", 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
      run32("srl16", 32'hDEAD_BEEF, 5'd16, 2'b01, 32'h0000_DEAD);

      // Zero shift in every mode, back-to-back
      ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         valid = 1'b1; data = 32'hDEAD_BEEF; shamt = 5'd0; mode = i[1:0];
         step();
      end
      valid = 1'b0;
      w = 0;
      while (!out_valid && w < 20) begin
         step();
         w++;
      end
      for (int i = 0; i < 4; i++) begin
         check("b2b_valid", 64'(out_valid), 64'd1);
         check("b2b_data", 64'(out_data), 64'hDEAD_BEEF);
         step();
      end
      check("b2b_no_dup", 64'(out_valid), 64'd0);

      // Random stream with downstream stall in cycles 3..10
      sent = 0; got = 0; cyc = 0; acc_at_drop = -1; stalled = 1'b0; hold_data = '0;
      while (got < 20 && cyc < 300) begin
         valid = (sent < 20);
         if (valid) begin
            data  = $urandom;
            shamt = 5'($urandom_range(0, 31));
            mode  = 2'($urandom_range(0, 3));
         end
         ready = !(cyc >= 3 && cyc <= 10);
         #1;
         if (stalled) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", 64'(out_data), 64'(hold_data));
         end
         if (valid && !ready_up && acc_at_drop < 0) acc_at_drop = sent;
         if (out_valid && ready) begin
            if (exp_q.size() == 0) begin
               check("stream_extra", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               check("stream_data", 64'(out_data), 64'(exp_q.pop_front()));
            end
            got++;
         end
         stalled   = out_valid && !ready;
         hold_data = out_data;
         if (valid && ready_up) begin
            exp_q.push_back(model(data, shamt, mode));
            sent++;
         end
         step();
         cyc++;
      end
      valid = 1'b0;
      ready = 1'b1;
      check("drop_after_accepts", 64'(acc_at_drop), 64'd5);
      check("stream_count", 64'(got), 64'd20);
      check("stream_sent", 64'(sent), 64'd20);

      // Reset with beats in flight
      for (int i = 0; i < 3; i++) begin
         valid = 1'b1; data = 32'h1234_0000 + 32'(i); shamt = 5'd1; mode = 2'b00;
         step();
      end
      valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_ready", 64'(ready_up), 64'd0);
      check("midrst_valid", 64'(out_valid), 64'd0);
      step();
      rst_n = 1'b1;
      #1;
      check("midrst_post_ready", 64'(ready_up), 64'd1);
      check("midrst_post_data", 64'(out_data), 64'd0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) seen++;
         step();
      end
      check("midrst_no_ghost", 64'(seen), 64'd0);
      run32("after_rst", 32'h0000_00F0, 5'd4, 2'b01, 32'h0000_000F);

      // Narrow build, two stages per register
      run8("w8_srl7", 8'h81, 3'd7, 2'b01, 8'h01);
      run8("w8_sll3", 8'h81, 3'd3, 2'b00, 8'h08);
      run8("w8_sra5", 8'h81, 3'd5, 2'b10, 8'hFC);
`ifdef BARREL_SHIFT_ROTATE_EN
      run8("w8_mode3", 8'h81, 3'd2, 2'b11, 8'h06);
`else
      run8("w8_mode3", 8'h81, 3'd2, 2'b11, 8'h04);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/barrel_shift_pipe.md
BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; power of two, 8..64.
REQ-002 SHALL have parameter REG_EVERY, default 1, number of 1-bit-weighted shift stages between pipeline registers; 1..log2(WIDTH).
REQ-003 SHALL have derived localparams SHAMT_W = log2(WIDTH) and NREG = ceil(SHAMT_W/REG_EVERY).
REQ-004 i_clk  in  1  clock; single clock domain, all logic on rising edge.
REQ-005 i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_valid  in  1  input beat valid.
REQ-007 o_ready  out  1  block accepts input this cycle.
REQ-008 i_data  in  WIDTH  operand.
REQ-009 i_shamt  in  SHAMT_W  shift amount.
REQ-010 i_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-011 o_valid  out  1  result valid.
REQ-012 i_ready  in  1  downstream accepts result.
REQ-013 o_data  out  WIDTH  result.

Function
REQ-014 Stage k (k=0..SHAMT_W-1) SHALL shift by 2^k when i_shamt[k]=1, else pass through; shamt bits and mode travel with the data.
REQ-015 SLL SHALL fill vacated LSBs with 0; SRL SHALL fill MSBs with 0; SRA SHALL fill MSBs with operand bit WIDTH-1.
REQ-016 i_shamt=0 SHALL return i_data unchanged in every mode.
REQ-017 A pipeline register SHALL follow every REG_EVERY stages and the final stage; latency from accept to o_valid SHALL be exactly NREG cycles with i_ready held high.
REQ-018 Input accepted when i_valid && o_ready; output consumed when o_valid && i_ready.
REQ-019 Each register slot SHALL hold a valid bit; slot n SHALL load when empty or when slot n+1 (or the output) advances in the same cycle.
REQ-020 o_ready SHALL be combinational: first slot empty OR first slot advancing this cycle; full throughput of one beat per cycle with i_ready high.
REQ-021 With i_ready low, o_valid, o_data SHALL hold stable; the pipe SHALL fill to NREG beats, then o_ready SHALL drop.
REQ-022 Simultaneous accept and consume at a full pipe SHALL neither lose nor duplicate a beat.
REQ-023 Beats SHALL exit in accept order; no beat dropped or reordered.

Reset
REQ-024 While i_rst_n=0 at a clock edge, all slot valid bits SHALL clear; o_valid=0, o_ready=0 during reset, o_ready=1 the first cycle after.
REQ-025 Data registers SHALL reset to 0 so o_data=0 after reset.
REQ-026 Reset mid-operation SHALL discard all in-flight beats; none emerges afterwards.

Configuration
REQ-027 Macro BARREL_SHIFT_ROTATE_EN defined: mode 11 SHALL perform rotate-left (bits shifted out of MSB re-enter at LSB).
REQ-028 Macro undefined: rotate logic SHALL be absent and mode 11 SHALL behave exactly as SLL.

Structure
REQ-029 Package barrel_shift_pkg SHALL hold the mode enum (SLL/SRL/SRA/ROL) and a function computing NREG.
REQ-030 One sub-module, barrel_shift_stage (parameter WIDTH, AMOUNT), SHALL implement a single combinational conditional shift-by-AMOUNT stage; the top instantiates SHAMT_W of them and owns all registers and handshake.

Verification
REQ-031 WIDTH=32, REG_EVERY=1, i_data=32'h8000_0001, shamt=4, SRA, i_ready=1 -> o_data=32'hF800_0000 exactly 5 cycles after accept.
REQ-032 i_data=32'h8000_0001, shamt=1, mode 11 -> with ROTATE_EN o_data=32'h0000_0003; without it 32'h0000_0002.
REQ-033 i_data=32'hDEAD_BEEF, shamt=0, all four modes back-to-back -> four outputs equal 32'hDEAD_BEEF on consecutive cycles.
REQ-034 Stream 20 random beats, i_ready low for cycles 3-10 -> o_ready drops after 5 accepts, all 20 results match model in order, o_data stable while stalled.
REQ-035 Assert i_rst_n=0 for one cycle with 3 beats in flight -> no o_valid afterwards until new input; o_ready=1 first post-reset cycle.
REQ-036 WIDTH=8, REG_EVERY=2, i_data=8'h81, shamt=7, SRL -> o_data=8'h01 after 2 cycles.
